// File: rtl/bmem_responder_if.sv
// Line-burst memory bus between a CPU-side initiator (master) and the bmem responder (slave).
interface bmem_responder_if;
    logic [31:0] bmem_addr;
    logic        bmem_read;
    logic        bmem_write;
    logic [63:0] bmem_wdata;
    logic        bmem_ready;
    logic [31:0] bmem_raddr;
    logic [63:0] bmem_rdata;
    logic        bmem_rvalid;
    logic        proto_err;

    modport master (
        output bmem_addr, bmem_read, bmem_write, bmem_wdata,
        input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid, proto_err
    );

    modport slave (
        input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
        output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid, proto_err
    );
endinterface

// File: rtl/bmem_responder.sv
// Line-burst memory responder: 32-byte lines, 4-beat writes, queued reads returned as 4-beat bursts.
// Optional protocol checker enabled by defining BMEM_RESP_PROTO_CHECK_EN.
module bmem_responder #(
    parameter int MEM_LINES = 256,
    parameter int LATENCY   = 4,
    parameter int QDEPTH    = 4
) (
    input logic             clk,
    input logic             rst,
    bmem_responder_if.slave bus
);
    // state    | meaning
    // W_IDLE   | no write burst; beat 0 may be accepted
    // W_B1..B3 | expecting write beat 1..3 of the captured line
    typedef enum logic [1:0] {W_IDLE, W_B1, W_B2, W_B3} wr_state_t;

    localparam int IW = (MEM_LINES > 1) ? $clog2(MEM_LINES) : 1;
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = $clog2(LATENCY + 1);
    // Countdown is offset by two: one cycle for the queue write, one for the output-stage load.
    localparam logic [CW-1:0] PUSH_CNT = (LATENCY >= 2) ? CW'(LATENCY - 2) : '0;
    localparam bit BYPASS = (LATENCY == 1);

    logic [255:0]  mem_q [MEM_LINES];

    wr_state_t     wr_state_q, wr_state_d;
    logic [IW-1:0] wr_line_q, wr_line_d;
    logic [255:0]  q_line_q [QDEPTH];
    logic [255:0]  q_line_d [QDEPTH];
    logic [26:0]   q_addr_q [QDEPTH];
    logic [26:0]   q_addr_d [QDEPTH];
    logic [CW-1:0] q_cnt_q  [QDEPTH];
    logic [CW-1:0] q_cnt_d  [QDEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          ready_q, ready_d;
    logic          rvalid_q, rvalid_d;
    logic [1:0]    beat_q, beat_d;
    logic [255:0]  out_line_q, out_line_d;
    logic [31:0]   raddr_q, raddr_d;
    logic [63:0]   rdata_q, rdata_d;

    logic          wr_en, wr_active, wr_acc, rd_acc, out_free, pop, push, bypass;
    logic [1:0]    wr_beat, nxt_beat;
    logic [IW-1:0] wr_idx, rd_idx;
    logic [255:0]  rd_line;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^bus.bmem_addr[4:0];
    assign rd_idx   = bus.bmem_addr[5 +: IW];
    assign rd_line  = mem_q[rd_idx];
    assign nxt_beat = beat_q + 2'd1;

    always_comb begin
        wr_state_d = wr_state_q;
        wr_line_d  = wr_line_q;
        wr_en      = 1'b0;
        wr_idx     = wr_line_q;
        wr_beat    = 2'd0;
        wr_active  = (wr_state_q != W_IDLE);
        wr_acc     = !wr_active && bus.bmem_write && ready_q;
        rd_acc     = !wr_active && bus.bmem_read && !bus.bmem_write && ready_q;

        case (wr_state_q)
            W_IDLE: if (wr_acc) begin
                wr_en      = 1'b1;
                wr_idx     = rd_idx;
                wr_line_d  = rd_idx;
                wr_state_d = W_B1;
            end
            W_B1: begin
                wr_beat    = 2'd1;
                wr_en      = bus.bmem_write;
                wr_state_d = bus.bmem_write ? W_B2 : W_IDLE;
            end
            W_B2: begin
                wr_beat    = 2'd2;
                wr_en      = bus.bmem_write;
                wr_state_d = bus.bmem_write ? W_B3 : W_IDLE;
            end
            default: begin
                wr_beat    = 2'd3;
                wr_en      = bus.bmem_write;
                wr_state_d = W_IDLE;
            end
        endcase

        q_line_d = q_line_q;
        q_addr_d = q_addr_q;
        for (int i = 0; i < QDEPTH; i++) begin
            q_cnt_d[i] = (q_cnt_q[i] == '0) ? '0 : q_cnt_q[i] - CW'(1);
        end
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        out_free = !rvalid_q || (beat_q == 2'd3);
        pop      = (count_q != '0) && (q_cnt_q[rd_ptr_q] == '0) && out_free;
        bypass   = BYPASS && rd_acc && (count_q == '0) && out_free;
        push     = rd_acc && !bypass;

        if (push) begin
            q_line_d[wr_ptr_q] = rd_line;
            q_addr_d[wr_ptr_q] = bus.bmem_addr[31:5];
            q_cnt_d[wr_ptr_q]  = PUSH_CNT;
            wr_ptr_d           = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
        ready_d = (count_d < (PW+1)'(QDEPTH));

        rvalid_d   = rvalid_q;
        beat_d     = beat_q;
        out_line_d = out_line_q;
        raddr_d    = raddr_q;
        rdata_d    = rdata_q;
        if (pop) begin
            rvalid_d   = 1'b1;
            beat_d     = 2'd0;
            out_line_d = q_line_q[rd_ptr_q];
            raddr_d    = {q_addr_q[rd_ptr_q], 5'd0};
            rdata_d    = q_line_q[rd_ptr_q][63:0];
        end else if (bypass) begin
            rvalid_d   = 1'b1;
            beat_d     = 2'd0;
            out_line_d = rd_line;
            raddr_d    = {bus.bmem_addr[31:5], 5'd0};
            rdata_d    = rd_line[63:0];
        end else if (rvalid_q) begin
            if (beat_q == 2'd3) begin
                rvalid_d = 1'b0;
            end else begin
                beat_d  = nxt_beat;
                rdata_d = out_line_q[{nxt_beat, 6'd0} +: 64];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state_q <= W_IDLE;
            wr_line_q  <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                q_line_q[i] <= '0;
                q_addr_q[i] <= '0;
                q_cnt_q[i]  <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ready_q    <= 1'b0;
            rvalid_q   <= 1'b0;
            beat_q     <= 2'd0;
            out_line_q <= '0;
            raddr_q    <= '0;
            rdata_q    <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_line_q  <= wr_line_d;
            q_line_q   <= q_line_d;
            q_addr_q   <= q_addr_d;
            q_cnt_q    <= q_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ready_q    <= ready_d;
            rvalid_q   <= rvalid_d;
            beat_q     <= beat_d;
            out_line_q <= out_line_d;
            raddr_q    <= raddr_d;
            rdata_q    <= rdata_d;
        end
    end

    // Storage is deliberately not reset; partially written lines survive a reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx][{wr_beat, 6'd0} +: 64] <= bus.bmem_wdata;
        end
    end

    assign bus.bmem_ready  = ready_q;
    assign bus.bmem_rvalid = rvalid_q;
    assign bus.bmem_raddr  = raddr_q;
    assign bus.bmem_rdata  = rdata_q;

`ifdef BMEM_RESP_PROTO_CHECK_EN
    logic proto_q, proto_d;

    always_comb begin
        proto_d = proto_q;
        if ((bus.bmem_read && bus.bmem_write) ||
            (bus.bmem_read && wr_active) ||
            (!bus.bmem_write && wr_active) ||
            (!wr_active && (bus.bmem_read || bus.bmem_write) && !ready_q)) begin
            proto_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            proto_q <= 1'b0;
        end else begin
            proto_q <= proto_d;
        end
    end

    assign bus.proto_err = proto_q;
`else
    assign bus.proto_err = 1'b0;
`endif
endmodule
